// File: rtl/result_uart_tx_pkg.sv
// Shared definitions for the result UART transmitter: line-ending characters,
// FSM state encodings and the cycles-per-bit computation.
package result_uart_tx_pkg;

  localparam logic [7:0] AsciiCr = 8'h0D;
  localparam logic [7:0] AsciiLf = 8'h0A;

  // Message-level sequencing. StSend covers the START/DATA/STOP framing, which the
  // serializer walks through for each byte.
  typedef enum logic [1:0] {StIdle, StCollect, StSend} msg_state_e;

  // Per-byte framing inside the serializer.
  typedef enum logic [1:0] {SerIdle, SerStart, SerData, SerStop} ser_state_e;

  // Cycles per bit, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Sends one byte as an 8N1 frame: START (0), data bits LSB first, STOP (1), each for DIV
// cycles. A start accepted on the last STOP cycle chains straight into the next frame.
// Ports:
//   clock  system clock
//   reset  asynchronous, active-low reset
//   start  begin a frame (honoured when idle or on the final STOP cycle)
//   data   byte to send; must be stable for the whole frame
//   txd    serial output, idle high (registered)
//   done   one-cycle pulse on the final STOP cycle
module uart_tx_serializer
  import result_uart_tx_pkg::*;
#(
  parameter int unsigned DIV = 608
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       done
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

  ser_state_e      st_q, st_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic            txd_q, txd_d;
  logic            bit_end;

  assign bit_end = (cnt_q == CntLast);

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    done  = 1'b0;
    unique case (st_q)
      SerIdle: begin
        if (start) begin
          st_d  = SerStart;
          cnt_d = '0;
        end
      end
      SerStart: begin
        if (bit_end) begin
          st_d  = SerData;
          cnt_d = '0;
          bit_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      SerData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) st_d = SerStop;
          else               bit_d = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      SerStop: begin
        if (bit_end) begin
          done  = 1'b1;
          cnt_d = '0;
          st_d  = start ? SerStart : SerIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: st_d = SerIdle;
    endcase

    // Output follows the next state so txd drops on the same edge that accepts start.
    txd_d = 1'b1;
    if (st_d == SerStart)     txd_d = 1'b0;
    else if (st_d == SerData) txd_d = data[bit_d];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q  <= SerIdle;
      cnt_q <= '0;
      bit_q <= '0;
      txd_q <= 1'b1;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      txd_q <= txd_d;
    end
  end

  assign txd = txd_q;

endmodule

// File: rtl/result_uart_tx.sv
// Collects a found-password message into a small buffer, then transmits it as 8N1 UART
// frames followed by CR LF. A rising edge on rewind while idle replays the last message.
// Ports:
//   clock     system clock
//   reset     asynchronous, active-low reset
//   in_data   message byte; in_valid qualifies it, in_last marks the final byte
//   in_ready  high while idle or collecting
//   rewind    synchronous replay request (edge-detected)
//   txd       serial output, idle high
//   busy      high while a message is being transmitted
module result_uart_tx
  import result_uart_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ = 70_000_000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned DEPTH  = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       rewind,
  output logic       txd,
  output logic       busy
);

  localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD);
  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned LenW  = AddrW + 1;
  // Read index runs past the message to cover CR (msg_len) and LF (msg_len+1).
  localparam int unsigned IdxW  = AddrW + 2;
  localparam logic [AddrW-1:0] AddrLast = AddrW'(DEPTH - 1);

  logic [7:0]      mem_q [DEPTH];
  msg_state_e      state_q, state_d;
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LenW-1:0] msg_len_q, msg_len_d;
  logic [IdxW-1:0] rd_idx_q, rd_idx_d;
  logic            rewind_q;

  logic            xfer, close_msg, rewind_edge;
  logic            ser_start, ser_done;
  logic [7:0]      tx_byte;
  logic [IdxW-1:0] len_ext;

  assign in_ready    = (state_q == StIdle) || (state_q == StCollect);
  assign busy        = (state_q == StSend);
  assign xfer        = in_valid & in_ready;
  // A full buffer closes the message even without in_last.
  assign close_msg   = xfer & (in_last | (wr_ptr_q == AddrLast));
  assign rewind_edge = rewind & ~rewind_q;
  assign len_ext     = {1'b0, msg_len_q};

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    msg_len_d = msg_len_q;
    rd_idx_d  = rd_idx_q;
    ser_start = 1'b0;
    unique case (state_q)
      StIdle, StCollect: begin
        if (xfer) begin
          // A transfer beats a simultaneous rewind edge.
          wr_ptr_d = wr_ptr_q + AddrW'(1);
          if (close_msg) begin
            msg_len_d = {1'b0, wr_ptr_q} + LenW'(1);
            rd_idx_d  = '0;
            state_d   = StSend;
            ser_start = 1'b1;
          end else begin
            state_d = StCollect;
          end
        end else if (state_q == StIdle && rewind_edge && msg_len_q != '0) begin
          rd_idx_d  = '0;
          state_d   = StSend;
          ser_start = 1'b1;
        end
      end
      StSend: begin
        if (ser_done) begin
          if (rd_idx_q == len_ext + IdxW'(1)) begin
            state_d  = StIdle;
            wr_ptr_d = '0;
          end else begin
            rd_idx_d  = rd_idx_q + IdxW'(1);
            ser_start = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Byte currently on the wire: buffer contents, then CR, then LF.
  always_comb begin
    tx_byte = AsciiLf;
    if (rd_idx_q < len_ext)       tx_byte = mem_q[rd_idx_q[AddrW-1:0]];
    else if (rd_idx_q == len_ext) tx_byte = AsciiCr;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      msg_len_q <= '0;
      rd_idx_q  <= '0;
      rewind_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      msg_len_q <= msg_len_d;
      rd_idx_q  <= rd_idx_d;
      rewind_q  <= rewind;
    end
  end

  // Storage only; validity is tracked by msg_len, so no reset is needed.
  always_ff @(posedge clock) begin
    if (xfer) mem_q[wr_ptr_q] <= in_data;
  end

  uart_tx_serializer #(
    .DIV(DIV)
  ) u_serializer (
    .clock(clock),
    .reset(reset),
    .start(ser_start),
    .data (tx_byte),
    .txd  (txd),
    .done (ser_done)
  );

endmodule
